mem_pic_arbiter: RTL and testbench

- Shares the single read port of the picture ROM (`mem_pic`: combinational `ADDRESS` -> `READ`) between two requesters.
- Requester 1: the CPU data path, single-word reads.
- Requester 2: a pixel-stream DMA, fixed-stride bursts.
- Arbitrates round-robin, drives the ROM address, and registers returned data back to the owning requester with valid/last strobes.

---
 rtl/mem_pic_arb_pkg.sv | 25 ++
 rtl/mem_pic_addr_gen.sv | 53 +++++
 rtl/mem_pic_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_pic_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pic_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_pic_arb_pkg
// Shared types and defaults for the picture-ROM arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, CPU_RD, DMA_BURST)
//   owner_e     : who was served last, drives the round-robin tie break
//   DEFAULT_*   : default width / stride / burst limit used by the top
// ---------------------------------------------------------------------------
package mem_pic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_RD    = 2'd1,
        DMA_BURST = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int DEFAULT_SIZE      = 8;
    localparam int DEFAULT_STRIDE    = 4;
    localparam int DEFAULT_BURST_MAX = 16;

endpackage

// File: rtl/mem_pic_addr_gen.sv
// ---------------------------------------------------------------------------
// mem_pic_addr_gen
// DMA address / beat counter for the picture-ROM arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture base address and beat count (burst start)
//   base       : burst start address
//   len        : number of beats in the burst (already clamped)
//   step       : one beat was issued this cycle, advance address and count
//   addr       : address of the beat to issue now
//   remaining  : beats still to issue, including the current one
//   last       : the current beat is the final one of the burst
// The address simply wraps modulo 2^SIZE when it runs past the top.
// ---------------------------------------------------------------------------
module mem_pic_addr_gen #(
    parameter int SIZE   = 8,
    parameter int STRIDE = 4,
    parameter int LW     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [SIZE-1:0] base,
    input  logic [LW-1:0]   len,
    input  logic            step,
    output logic [SIZE-1:0] addr,
    output logic [LW-1:0]   remaining,
    output logic            last
);

    logic [SIZE-1:0] addr_q;
    logic [LW-1:0]   rem_q;

    // Load wins over step so a new burst always starts from its own base;
    // when neither is asserted the counter holds, which is what freezes the
    // burst while a preempting CPU read is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= base;
            rem_q  <= len;
        end else if (step) begin
            addr_q <= addr_q + SIZE'(STRIDE);
            rem_q  <= rem_q - LW'(1);
        end
    end

    assign addr      = addr_q;
    assign remaining = rem_q;
    assign last      = (rem_q == LW'(1));

endmodule

// File: rtl/mem_pic_arbiter.sv
// ---------------------------------------------------------------------------
// mem_pic_arbiter
// Shares the single combinational read port of the picture ROM between the
// CPU data path (single reads) and a pixel DMA (fixed-stride bursts), with
// round-robin arbitration and registered read data back to each requester.
//
// Ports
//   CLK, RST_N          : clock, asynchronous active-low reset
//   CPU_REQ/ADDR        : CPU read request and address (sampled on grant)
//   CPU_GNT             : one-cycle grant pulse
//   CPU_VALID/RDATA     : read data, valid two cycles after the grant
//   DMA_REQ/BASE/LEN    : burst request, start address, beat count
//   DMA_GNT             : one-cycle grant pulse
//   DMA_VALID/RDATA     : beat data, one cycle after each beat address
//   DMA_LAST            : marks the final beat of a burst
//   DMA_BUSY            : burst in flight (cycle after grant .. DMA_LAST)
//   MEM_ADDR / MEM_READ : ROM address out, ROM data in
//
// Build option
//   MEM_PIC_ARB_CPU_PREEMPT_EN : when defined, a CPU request may slip in
//   between two DMA beats; the burst is frozen and resumes afterwards.
//   When undefined, DMA bursts are atomic.
// ---------------------------------------------------------------------------
module mem_pic_arbiter
    import mem_pic_arb_pkg::*;
#(
    parameter  int SIZE      = DEFAULT_SIZE,
    parameter  int STRIDE    = DEFAULT_STRIDE,
    parameter  int BURST_MAX = DEFAULT_BURST_MAX,
    localparam int LW        = $clog2(BURST_MAX) + 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            CPU_REQ,
    input  logic [SIZE-1:0] CPU_ADDR,
    output logic            CPU_GNT,
    output logic            CPU_VALID,
    output logic [SIZE-1:0] CPU_RDATA,
    input  logic            DMA_REQ,
    input  logic [SIZE-1:0] DMA_BASE,
    input  logic [LW-1:0]   DMA_LEN,
    output logic            DMA_GNT,
    output logic            DMA_VALID,
    output logic [SIZE-1:0] DMA_RDATA,
    output logic            DMA_LAST,
    output logic            DMA_BUSY,
    output logic [SIZE-1:0] MEM_ADDR,
    input  logic [SIZE-1:0] MEM_READ
);

    arb_state_e      state_q, state_d;
    owner_e          lastOwner_q, lastOwner_d;
    logic            resume_q, resume_d;
    logic [SIZE-1:0] cpuAddr_q;
    logic            cpuValid_q;
    logic [SIZE-1:0] cpuRdata_q;
    logic            dmaValid_q;
    logic            dmaLast_q;
    logic [SIZE-1:0] dmaRdata_q;
    logic            dmaBusy_q;

    logic            cpuGnt;
    logic            dmaGnt;
    logic            dmaStart;
    logic [LW-1:0]   dmaLenClamped;
    logic [SIZE-1:0] genAddr;
    logic [LW-1:0]   genRemaining;
    logic            genLast;
    logic            moreBeats;

    // Beats beyond the current one; false on the final beat of a burst.
    assign moreBeats = (genRemaining > LW'(1));

    // A zero-length request is granted but never starts a burst.
    assign dmaStart = dmaGnt && (dmaLenClamped != '0);

    mem_pic_addr_gen #(
        .SIZE   (SIZE),
        .STRIDE (STRIDE),
        .LW     (LW)
    ) u_addr_gen (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (dmaStart),
        .base      (DMA_BASE),
        .len       (dmaLenClamped),
        .step      (state_q == DMA_BURST),
        .addr      (genAddr),
        .remaining (genRemaining),
        .last      (genLast)
    );

    // Arbitration and next-state logic. Grants are combinational so a
    // requester sees its grant in the same cycle it is chosen. The tie break
    // favours whichever side was not served last. Grants are gated by RST_N
    // so every output reads zero while reset is asserted.
    always_comb begin
        cpuGnt        = 1'b0;
        dmaGnt        = 1'b0;
        state_d       = state_q;
        lastOwner_d   = lastOwner_q;
        resume_d      = resume_q;
        dmaLenClamped = (DMA_LEN > LW'(BURST_MAX)) ? LW'(BURST_MAX) : DMA_LEN;
        case (state_q)
            IDLE: begin
                if (RST_N) begin
                    if (CPU_REQ && (!DMA_REQ || lastOwner_q == OWN_DMA)) begin
                        cpuGnt  = 1'b1;
                        state_d = CPU_RD;
                    end else if (DMA_REQ) begin
                        dmaGnt = 1'b1;
                        if (dmaLenClamped != '0) begin
                            state_d = DMA_BURST;
                        end else begin
                            lastOwner_d = OWN_DMA;
                        end
                    end
                end
            end
            CPU_RD: begin
                lastOwner_d = OWN_CPU;
                state_d     = resume_q ? DMA_BURST : IDLE;
                resume_d    = 1'b0;
            end
            DMA_BURST: begin
                if (!moreBeats) begin
                    state_d     = IDLE;
                    lastOwner_d = OWN_DMA;
                end
`ifdef MEM_PIC_ARB_CPU_PREEMPT_EN
                else if (CPU_REQ) begin
                    // The current beat still issues; the CPU read follows
                    // and the burst picks up where it left off.
                    cpuGnt   = 1'b1;
                    state_d  = CPU_RD;
                    resume_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and all registered outputs. ROM data is captured in the
    // cycle its address is driven and presented with VALID one cycle later;
    // data registers hold their value when nothing new arrives.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            lastOwner_q <= OWN_DMA;
            resume_q    <= 1'b0;
            cpuAddr_q   <= '0;
            cpuValid_q  <= 1'b0;
            cpuRdata_q  <= '0;
            dmaValid_q  <= 1'b0;
            dmaLast_q   <= 1'b0;
            dmaRdata_q  <= '0;
            dmaBusy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            resume_q    <= resume_d;
            if (cpuGnt) begin
                cpuAddr_q <= CPU_ADDR;
            end
            cpuValid_q <= (state_q == CPU_RD);
            if (state_q == CPU_RD) begin
                cpuRdata_q <= MEM_READ;
            end
            dmaValid_q <= (state_q == DMA_BURST);
            dmaLast_q  <= (state_q == DMA_BURST) && genLast;
            if (state_q == DMA_BURST) begin
                dmaRdata_q <= MEM_READ;
            end
            if (dmaStart) begin
                dmaBusy_q <= 1'b1;
            end else if (dmaLast_q) begin
                dmaBusy_q <= 1'b0;
            end
        end
    end

    // The ROM address is parked at zero whenever no read is in progress.
    always_comb begin
        case (state_q)
            CPU_RD:    MEM_ADDR = cpuAddr_q;
            DMA_BURST: MEM_ADDR = genAddr;
            default:   MEM_ADDR = '0;
        endcase
    end

    assign CPU_GNT   = cpuGnt;
    assign CPU_VALID = cpuValid_q;
    assign CPU_RDATA = cpuRdata_q;
    assign DMA_GNT   = dmaGnt;
    assign DMA_VALID = dmaValid_q;
    assign DMA_RDATA = dmaRdata_q;
    assign DMA_LAST  = dmaLast_q;
    assign DMA_BUSY  = dmaBusy_q;

endmodule

// File: tb/tb_mem_pic_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_pic_arbiter
// Directed bench for mem_pic_arbiter with a small ROM model on MEM_READ.
// Inputs change 1 ns after the rising edge and outputs are sampled 2 ns
// after it, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_mem_pic_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       CPU_REQ;
    logic [7:0] CPU_ADDR;
    logic       CPU_GNT;
    logic       CPU_VALID;
    logic [7:0] CPU_RDATA;
    logic       DMA_REQ;
    logic [7:0] DMA_BASE;
    logic [4:0] DMA_LEN;
    logic       DMA_GNT;
    logic       DMA_VALID;
    logic [7:0] DMA_RDATA;
    logic       DMA_LAST;
    logic       DMA_BUSY;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_READ;

    int errors = 0;
    int checks = 0;

    mem_pic_arbiter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CPU_REQ   (CPU_REQ),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_GNT   (CPU_GNT),
        .CPU_VALID (CPU_VALID),
        .CPU_RDATA (CPU_RDATA),
        .DMA_REQ   (DMA_REQ),
        .DMA_BASE  (DMA_BASE),
        .DMA_LEN   (DMA_LEN),
        .DMA_GNT   (DMA_GNT),
        .DMA_VALID (DMA_VALID),
        .DMA_RDATA (DMA_RDATA),
        .DMA_LAST  (DMA_LAST),
        .DMA_BUSY  (DMA_BUSY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_READ  (MEM_READ)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Picture ROM stand-in: every address maps to a distinct byte.
    function automatic logic [7:0] romData(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h5A;
    endfunction

    always_comb MEM_READ = romData(MEM_ADDR);

    // Safety net in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cpuReq, input logic [7:0] cpuAddr,
                                 input logic dmaReq, input logic [7:0] dmaBase,
                                 input logic [4:0] dmaLen);
        CPU_REQ  = cpuReq;
        CPU_ADDR = cpuAddr;
        DMA_REQ  = dmaReq;
        DMA_BASE = dmaBase;
        DMA_LEN  = dmaLen;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".cpuGnt"},   CPU_GNT,   0);
        checkOutput({tag, ".cpuValid"}, CPU_VALID, 0);
        checkOutput({tag, ".cpuRdata"}, CPU_RDATA, 0);
        checkOutput({tag, ".dmaGnt"},   DMA_GNT,   0);
        checkOutput({tag, ".dmaValid"}, DMA_VALID, 0);
        checkOutput({tag, ".dmaRdata"}, DMA_RDATA, 0);
        checkOutput({tag, ".dmaLast"},  DMA_LAST,  0);
        checkOutput({tag, ".dmaBusy"},  DMA_BUSY,  0);
        checkOutput({tag, ".memAddr"},  MEM_ADDR,  0);
    endtask

    // Runs a granted burst of n beats starting the cycle after DMA_GNT.
    // Cycle k issues beat k (k < n); data for beat k-1 is visible; the final
    // cycle k == n carries DMA_LAST. A CPU request held by the bench is
    // expected to be granted exactly on that final cycle.
    task automatic runBurst(input logic [7:0] base, input int n,
                            input int raiseAt, input logic [7:0] cpuAddr);
        logic [7:0] a;
        for (int k = 0; k <= n; k++) begin
            tick();
            if (k == 0) DMA_REQ = 1'b0;
            if (k == raiseAt) begin
                CPU_REQ  = 1'b1;
                CPU_ADDR = cpuAddr;
            end
            #1;
            if (k < n) begin
                a = base + 8'(4 * k);
                checkOutput("burstAddr", MEM_ADDR, a);
            end
            checkOutput("burstBusy", DMA_BUSY, 1);
            checkOutput("burstValid", DMA_VALID, (k > 0));
            if (k > 0) begin
                a = base + 8'(4 * (k - 1));
                checkOutput("burstRdata", DMA_RDATA, romData(a));
            end
            checkOutput("burstLast", DMA_LAST, (k == n));
            checkOutput("burstCpuGnt", CPU_GNT, (CPU_REQ && k == n));
            checkOutput("burstDmaGnt", DMA_GNT, 0);
        end
    endtask

    // Follows a CPU grant: drop the request, see the address, then the data.
    task automatic finishCpuRead(input logic [7:0] addr);
        tick();
        CPU_REQ = 1'b0;
        #1;
        checkOutput("cpuRdAddr", MEM_ADDR, addr);
        checkOutput("cpuRdBusy", DMA_BUSY, 0);
        checkOutput("cpuRdDmaValid", DMA_VALID, 0);
        checkOutput("cpuRdDmaLast", DMA_LAST, 0);
        checkOutput("cpuRdValidEarly", CPU_VALID, 0);
        tick();
        #1;
        checkOutput("cpuValid", CPU_VALID, 1);
        checkOutput("cpuRdata", CPU_RDATA, romData(addr));
    endtask

    initial begin
        RST_N = 1'b0;
        applyStimulus(0, 8'h00, 0, 8'h00, 5'd0);
        #3;
        checkAllZero("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Simultaneous requests straight out of reset: CPU wins the tie.
        tick();
        applyStimulus(1, 8'h08, 1, 8'h00, 5'd9);
        #1;
        checkOutput("tieCpuGnt", CPU_GNT, 1);
        checkOutput("tieDmaGnt", DMA_GNT, 0);
        checkOutput("tieIdleAddr", MEM_ADDR, 0);

        tick();
        applyStimulus(0, 8'h08, 1, 8'h00, 5'd9);
        #1;
        checkOutput("cpuRdAddr08", MEM_ADDR, 8'h08);
        checkOutput("cpuRdNoDmaGnt", DMA_GNT, 0);
        checkOutput("cpuRdNoValid", CPU_VALID, 0);

`ifndef MEM_PIC_ARB_CPU_PREEMPT_EN
        // Both requesting again: the CPU was served last, so DMA goes first
        // and the CPU is served right after the burst.
        tick();
        applyStimulus(1, 8'h55, 1, 8'h00, 5'd9);
        #1;
        checkOutput("cpuValid08", CPU_VALID, 1);
        checkOutput("cpuRdata08", CPU_RDATA, romData(8'h08));
        checkOutput("tie2DmaGnt", DMA_GNT, 1);
        checkOutput("tie2CpuGnt", CPU_GNT, 0);
        runBurst(8'h00, 9, -1, 8'h00);
        finishCpuRead(8'h55);

        // Wrapping burst with the length clamped to 16; CPU raised mid-burst.
        tick();
        applyStimulus(0, 8'h00, 1, 8'hF8, 5'd31);
        #1;
        checkOutput("wrapDmaGnt", DMA_GNT, 1);
        runBurst(8'hF8, 16, 7, 8'h77);
        finishCpuRead(8'h77);
`else
        tick();
        applyStimulus(0, 8'h00, 1, 8'h00, 5'd9);
        #1;
        checkOutput("cpuValid08", CPU_VALID, 1);
        checkOutput("cpuRdata08", CPU_RDATA, romData(8'h08));
        checkOutput("dmaAloneGnt", DMA_GNT, 1);
        runBurst(8'h00, 9, -1, 8'h00);
        tick();
        #1;
        checkOutput("busyDrop", DMA_BUSY, 0);

        // Preemption: CPU slips in after beat 2, burst resumes afterwards.
        tick();
        applyStimulus(0, 8'h00, 1, 8'h10, 5'd4);
        #1;
        checkOutput("preDmaGnt", DMA_GNT, 1);
        tick();
        DMA_REQ = 1'b0;
        #1;
        checkOutput("preAddr0", MEM_ADDR, 8'h10);
        tick();
        applyStimulus(1, 8'h40, 0, 8'h10, 5'd4);
        #1;
        checkOutput("preAddr1", MEM_ADDR, 8'h14);
        checkOutput("preCpuGnt", CPU_GNT, 1);
        checkOutput("preRdata0", DMA_RDATA, romData(8'h10));
        tick();
        CPU_REQ = 1'b0;
        #1;
        checkOutput("preAddrCpu", MEM_ADDR, 8'h40);
        checkOutput("preRdata1", DMA_RDATA, romData(8'h14));
        checkOutput("preBusyCpu", DMA_BUSY, 1);
        tick();
        #1;
        checkOutput("preAddr2", MEM_ADDR, 8'h18);
        checkOutput("preDmaIdle", DMA_VALID, 0);
        checkOutput("preCpuValid", CPU_VALID, 1);
        checkOutput("preCpuRdata", CPU_RDATA, romData(8'h40));
        tick();
        #1;
        checkOutput("preAddr3", MEM_ADDR, 8'h1C);
        checkOutput("preLastEarly", DMA_LAST, 0);
        tick();
        #1;
        checkOutput("preRdata3", DMA_RDATA, romData(8'h1C));
        checkOutput("preLast", DMA_LAST, 1);
        checkOutput("preBusyLast", DMA_BUSY, 1);
        tick();
        #1;
        checkOutput("preBusyDrop", DMA_BUSY, 0);
`endif

        // Reset in the middle of a burst (during beat 3).
        tick();
        applyStimulus(0, 8'h00, 1, 8'h80, 5'd8);
        #1;
        checkOutput("rstDmaGnt", DMA_GNT, 1);
        tick();
        DMA_REQ = 1'b0;
        tick();
        tick();
        #1;
        checkOutput("rstBeat3Addr", MEM_ADDR, 8'h88);
        RST_N = 1'b0;
        #1;
        checkAllZero("midRst");
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checkOutput("rstHoldValid", DMA_VALID, 0);
            checkOutput("rstHoldLast", DMA_LAST, 0);
            checkOutput("rstHoldBusy", DMA_BUSY, 0);
        end
        tick();
        RST_N = 1'b1;
        #1;
        checkOutput("rstRelAddr", MEM_ADDR, 0);
        checkOutput("rstRelLast", DMA_LAST, 0);
        tick();
        applyStimulus(1, 8'h21, 0, 8'h00, 5'd0);
        #1;
        checkOutput("postRstCpuGnt", CPU_GNT, 1);
        finishCpuRead(8'h21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
